// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - three-stage pipelined IEEE-754 floating-point multiplier
//
// Multiplies two IEEE-754 operands of parameterised exponent/fraction width.
// Stages:
//   S1 unpack/classify, S2 normalise, S3 round/pack.
//   S3 is the output register.
// There is one global stall: the whole pipe advances when the output register
// is empty or is being consumed.
// Subnormal inputs are flushed to zero.
// Results that underflow are flushed to signed zero.
//
// Ports:
//   Clk        clock, rising edge
//   Rst        synchronous active-high reset, discards all in-flight work
//   in_valid   operand pair valid
//   in_ready   pipe accepts operands this cycle
//   in_a/in_b  operands, {sign, exponent, fraction}
//   in_rnd     rounding mode: 00 RTZ, 01 RNE, 10 RNA, 11 RNE
//   in_tag     user tag carried with the operation
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_c      product
//   out_flags  {invalid, overflow, underflow, inexact} for this result
//   out_tag    tag of this result

module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [1:0]             in_rnd,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_c,
    output logic [3:0]             out_flags,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;       // signed exponent datapath width
    localparam int SW = MAN_W + 1;       // significand width incl. hidden bit
    localparam int PW = 2 * SW;          // full product width

    localparam logic [EW-1:0]    BIAS_X    = EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic [EW-1:0]    EMAX_X    = EW'((2 ** EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [EXP_W-1:0] EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [MAN_W-1:0] FRAC_ONES = '1;
    localparam logic [MAN_W-1:0] FRAC_ZERO = '0;
    localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // Global stall: every stage register holds, bubbles included.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // ------------------------------------------------------------------
    // S1: unpack / classify
    // ------------------------------------------------------------------
    logic             a_s, b_s;
    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W-1:0] a_f, b_f;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic             nan_d, inf_d, zero_d;
    logic [EW-1:0]    e1_d;
    logic [PW-1:0]    prod_d;

    assign a_s = in_a[W-1];
    assign b_s = in_b[W-1];
    assign a_e = in_a[W-2:MAN_W];
    assign b_e = in_b[W-2:MAN_W];
    assign a_f = in_a[MAN_W-1:0];
    assign b_f = in_b[MAN_W-1:0];

    // A zero exponent is zero regardless of fraction (flush-to-zero).
    assign a_zero = (a_e == '0);
    assign b_zero = (b_e == '0);
    assign a_inf  = (a_e == EXP_ONES) && (a_f == '0);
    assign b_inf  = (b_e == EXP_ONES) && (b_f == '0);
    assign a_nan  = (a_e == EXP_ONES) && (a_f != '0);
    assign b_nan  = (b_e == EXP_ONES) && (b_f != '0);

    assign nan_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    assign inf_d  = a_inf || b_inf;
    assign zero_d = a_zero || b_zero;

    // Two's-complement in EW bits; can go negative for tiny products.
    assign e1_d   = {2'b00, a_e} + {2'b00, b_e} - BIAS_X;
    assign prod_d = {{SW{1'b0}}, 1'b1, a_f} * {{SW{1'b0}}, 1'b1, b_f};

    logic             s1_valid;
    logic             s1_sign, s1_nan, s1_inf, s1_zero;
    logic [EW-1:0]    s1_e;
    logic [PW-1:0]    s1_prod;
    logic [1:0]       s1_rnd;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= a_s ^ b_s;
            s1_nan   <= nan_d;
            s1_inf   <= inf_d;
            s1_zero  <= zero_d;
            s1_e     <= e1_d;
            s1_prod  <= prod_d;
            s1_rnd   <= in_rnd;
            s1_tag   <= in_tag;
        end
    end

    // ------------------------------------------------------------------
    // S2: normalise, extract guard/round/sticky, decide increment
    // ------------------------------------------------------------------
    logic          msb;
    logic [PW-1:0] norm;
    logic [SW-1:0] kept;
    logic          guard, rnd_bit, sticky;
    logic          inc_d, inexact_d;
    logic [EW-1:0] e2_d;

    // The product of two [1,2) significands is in [1,4).
    // Aligning the leading one to the top keeps a single extraction point.
    assign msb     = s1_prod[PW-1];
    assign norm    = msb ? s1_prod : {s1_prod[PW-2:0], 1'b0};
    assign kept    = norm[PW-1:MAN_W+1];
    assign guard   = norm[MAN_W];
    assign rnd_bit = norm[MAN_W-1];
    assign sticky  = |norm[MAN_W-2:0];
    assign e2_d    = s1_e + {{(EW-1){1'b0}}, msb};

    assign inexact_d = guard || rnd_bit || sticky;

    always_comb begin
        inc_d = 1'b0;
        case (s1_rnd)
            2'b00:   inc_d = 1'b0;                                    // RTZ
            2'b10:   inc_d = guard;                                   // RNA
            default: inc_d = guard && (rnd_bit || sticky || kept[0]); // RNE
        endcase
    end

    logic             s2_valid;
    logic             s2_sign, s2_nan, s2_inf, s2_zero, s2_rtz;
    logic [EW-1:0]    s2_e;
    logic [SW-1:0]    s2_kept;
    logic             s2_inc, s2_inexact;
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s2_valid <= 1'b0;
        end else if (advance) begin
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_nan     <= s1_nan;
            s2_inf     <= s1_inf;
            s2_zero    <= s1_zero;
            s2_rtz     <= (s1_rnd == 2'b00);
            s2_e       <= e2_d;
            s2_kept    <= kept;
            s2_inc     <= inc_d;
            s2_inexact <= inexact_d;
            s2_tag     <= s1_tag;
        end
    end

    // ------------------------------------------------------------------
    // S3: round, range check, special override, pack
    // ------------------------------------------------------------------
    logic [SW:0]      sum;
    logic             carry;
    logic [MAN_W-1:0] frac3;
    logic [EW-1:0]    e3;
    logic             ovf, unf;
    logic [W-1:0]     res_c;
    logic [3:0]       res_f;

    assign sum   = {1'b0, s2_kept} + {{SW{1'b0}}, s2_inc};
    assign carry = sum[SW];
    // On carry-out the significand is exactly 10.00..0.
    // Shifting right leaves a zero fraction.
    assign frac3 = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
    assign e3    = s2_e + {{(EW-1){1'b0}}, carry};
    assign ovf   = ($signed(e3) >= $signed(EMAX_X));
    assign unf   = e3[EW-1] || (e3 == '0);

    always_comb begin
        res_c = {s2_sign, e3[EXP_W-1:0], frac3};
        res_f = {3'b000, s2_inexact};
        if (ovf) begin
            res_f = 4'b0101;
            res_c = s2_rtz ? {s2_sign, EXP_MAXF, FRAC_ONES}
                           : {s2_sign, EXP_ONES, FRAC_ZERO};
        end else if (unf) begin
            // Non-special operands always carry a hidden one.
            // The exact product is therefore nonzero.
            // Flushing it is always inexact.
            res_f = 4'b0011;
            res_c = {s2_sign, {(W-1){1'b0}}};
        end

        if (s2_nan) begin
            res_c = QNAN;
            res_f = 4'b1000;
        end else if (s2_inf) begin
            res_c = {s2_sign, EXP_ONES, FRAC_ZERO};
            res_f = 4'b0000;
        end else if (s2_zero) begin
            res_c = {s2_sign, {(W-1){1'b0}}};
            res_f = 4'b0000;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_flags <= '0;
            out_tag   <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_c     <= res_c;
                out_flags <= res_f;
                out_tag   <= s2_tag;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - directed self-checking bench for fp_mul_pipe

module tb_fp_mul_pipe;

    logic        Clk;
    logic        Rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_rnd;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_c;
    logic [3:0]  out_flags;
    logic [3:0]  out_tag;

    int n_checks = 0;
    int n_fail   = 0;

    fp_mul_pipe #(
        .EXP_W(8),
        .MAN_W(23),
        .TAG_W(4)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rnd    (in_rnd),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_flags (out_flags),
        .out_tag   (out_tag)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // One operation with out_ready high.
    // Checks acceptance, 3-edge latency, result, flags and tag.
    // Called and returns at posedge+1.
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] rnd, input logic [3:0] tag,
                          input logic [31:0] ec, input logic [3:0] ef);
        int lat;
        in_a = a; in_b = b; in_rnd = rnd; in_tag = tag; in_valid = 1'b1;
        #1;
        check({nm, "_in_ready"}, in_ready, 1);
        @(posedge Clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge Clk); #1;
            lat++;
        end
        check({nm, "_latency"}, lat, 3);
        check({nm, "_c"}, out_c, ec);
        check({nm, "_flags"}, out_flags, ef);
        check({nm, "_tag"}, out_tag, tag);
    endtask

    logic [31:0] bp_a [0:5];
    logic [31:0] bp_c [0:5];
    int sent, got, first_stall, seen;

    initial begin
        bp_a[0] = 32'h3FC00000; bp_c[0] = 32'h40400000;
        bp_a[1] = 32'h40000000; bp_c[1] = 32'h40800000;
        bp_a[2] = 32'h3F800000; bp_c[2] = 32'h40000000;
        bp_a[3] = 32'h40400000; bp_c[3] = 32'h40C00000;
        bp_a[4] = 32'hBF800000; bp_c[4] = 32'hC0000000;
        bp_a[5] = 32'h40800000; bp_c[5] = 32'h41000000;

        Rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_rnd = 2'b01;
        in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_c", out_c, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_out_tag", out_tag, 0);
        Rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(posedge Clk); #1;

        run_op("basic",    32'h3FC00000, 32'h40000000, 2'b01, 4'd1, 32'h40400000, 4'b0000);
        run_op("tie_rtz",  32'h3F800003, 32'h3FC00000, 2'b00, 4'd2, 32'h3FC00004, 4'b0001);
        run_op("tie_rne",  32'h3F800003, 32'h3FC00000, 2'b01, 4'd3, 32'h3FC00004, 4'b0001);
        run_op("tie_rna",  32'h3F800003, 32'h3FC00000, 2'b10, 4'd4, 32'h3FC00005, 4'b0001);
        run_op("tie_m11",  32'h3F800003, 32'h3FC00000, 2'b11, 4'd5, 32'h3FC00004, 4'b0001);
        run_op("ovf_rne",  32'h7F000000, 32'h7F000000, 2'b01, 4'd6, 32'h7F800000, 4'b0101);
        run_op("ovf_rtz",  32'h7F000000, 32'h7F000000, 2'b00, 4'd7, 32'h7F7FFFFF, 4'b0101);
        run_op("inf_zero", 32'h7F800000, 32'h00000000, 2'b01, 4'd8, 32'h7FC00000, 4'b1000);
        run_op("ninf_one", 32'hFF800000, 32'h3F800000, 2'b01, 4'd9, 32'hFF800000, 4'b0000);
        run_op("unf",      32'h00800000, 32'h00800000, 2'b01, 4'd10, 32'h00000000, 4'b0011);
        run_op("nan_in",   32'h7FC00001, 32'h3F800000, 2'b01, 4'd11, 32'h7FC00000, 4'b1000);
        run_op("nzero",    32'h80000000, 32'h3F800000, 2'b01, 4'd12, 32'h80000000, 4'b0000);
        run_op("subn_ftz", 32'h00000001, 32'h3F800000, 2'b01, 4'd13, 32'h00000000, 4'b0000);
        @(posedge Clk); #1;

        // Backpressure: out_ready low for the first 5 cycles.
        sent = 0; got = 0; first_stall = -1;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            out_ready = (cyc >= 5);
            if (sent < 6) begin
                in_valid = 1'b1; in_a = bp_a[sent]; in_b = 32'h40000000;
                in_rnd = 2'b01; in_tag = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                check("bp_c", out_c, bp_c[got]);
                check("bp_tag", out_tag, 32'(got));
                got++;
            end
            if (in_valid && !in_ready && first_stall < 0) first_stall = sent;
            if (in_valid && in_ready) sent++;
            @(posedge Clk); #1;
        end
        in_valid = 1'b0;
        check("bp_stall_after_fill", first_stall, 3);
        check("bp_sent", sent, 6);
        check("bp_got", got, 6);
        check("bp_drained", out_valid, 0);

        // Reset with three operations in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h40000000;
            in_rnd = 2'b01; in_tag = 4'(9 + i);
            @(posedge Clk); #1;
        end
        in_valid = 1'b0;
        check("mr_full_valid", out_valid, 1);
        check("mr_full_in_ready", in_ready, 0);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        check("mr_out_valid", out_valid, 0);
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            if (out_valid) seen++;
            @(posedge Clk); #1;
        end
        check("mr_no_ghost", seen, 0);
        run_op("mr_after", 32'h40400000, 32'h40000000, 2'b01, 4'd14, 32'h40C00000, 4'b0000);
        @(posedge Clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
